frame_bank_switch: RTL

Parametrised N-bank frame-buffer write/read switch between the grayscale pixel path and the frame memories.
- Steers each incoming pixel to the current write bank and rotates banks on frame end.
- Publishes the most recently completed bank to the tracker's read side.
- Protects a bank the reader has locked; otherwise the frame is dropped.
- Generalises the two-bank, frame-parity-driven combinational switch to registered, handshaked, N-bank operation.

---
 rtl/frame_bank_pkg.sv | 28 ++
 rtl/frame_bank_switch_if.sv | 43 ++++
 rtl/frame_bank_ptr.sv | 100 ++++++++++
 rtl/frame_bank_switch.sv | 84 ++++++++
 4 files changed

// File: rtl/frame_bank_pkg.sv
// Shared widths, state/decision encodings and sizing helper for the frame bank switch.
// FRAME_LEN_CHECK_EN (optional) enables frame length checking in the switch.
package frame_bank_pkg;

    localparam int unsigned DATA_W_DEF       = 12;
    localparam int unsigned NUM_BANKS_DEF    = 2;
    localparam int unsigned BANK_W_DEF       = 3;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned FRAME_PIXELS_DEF = 307200;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } bankState_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUBLISH = 2'd1,
        DROP    = 2'd2
    } decision_e;

    // Minimum bank index width able to address n banks.
    function automatic int unsigned bankWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_bank_switch_if.sv
// Pixel-in / bank-out bus of the frame bank switch.
// FRAME_LEN_CHECK_EN adds the oLEN_ERR pulse.
interface frame_bank_switch_if #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BANK_W    = 3,
    parameter int unsigned CNT_W     = 16
);
    logic [DATA_W-1:0]           iGray;
    logic                        iPIX_VALID;
    logic                        iFRAME_END;
    logic                        iRD_LOCK;
    logic [NUM_BANKS*DATA_W-1:0] oBANK_DATA;
    logic [NUM_BANKS-1:0]        oBANK_WE;
    logic [BANK_W-1:0]           oWR_BANK;
    logic [BANK_W-1:0]           oRD_BANK;
    logic                        oRD_VALID;
    logic                        oFRAME_RDY;
    logic                        oDROP;
    logic [CNT_W-1:0]            oFRAME_CNT;
    logic [CNT_W-1:0]            oDROP_CNT;
`ifdef FRAME_LEN_CHECK_EN
    logic                        oLEN_ERR;
`endif

    modport master (
        output iGray, iPIX_VALID, iFRAME_END, iRD_LOCK,
        input  oBANK_DATA, oBANK_WE, oWR_BANK, oRD_BANK, oRD_VALID,
        input  oFRAME_RDY, oDROP, oFRAME_CNT, oDROP_CNT
`ifdef FRAME_LEN_CHECK_EN
        , input oLEN_ERR
`endif
    );

    modport slave (
        input  iGray, iPIX_VALID, iFRAME_END, iRD_LOCK,
        output oBANK_DATA, oBANK_WE, oWR_BANK, oRD_BANK, oRD_VALID,
        output oFRAME_RDY, oDROP, oFRAME_CNT, oDROP_CNT
`ifdef FRAME_LEN_CHECK_EN
        , output oLEN_ERR
`endif
    );
endinterface

// File: rtl/frame_bank_ptr.sv
// Write/read bank pointers, lock check, frame/drop counters and fill-state machine.
// FRAME_LEN_CHECK_EN adds the lenBad input and lenErr pulse.
module frame_bank_ptr
    import frame_bank_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned BANK_W    = BANK_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              frameEnd,
    input  logic              pixValid,
    input  logic              pixNz,
    input  logic              rdLock,
`ifdef FRAME_LEN_CHECK_EN
    input  logic              lenBad,
    output logic              lenErr,
`endif
    output logic [BANK_W-1:0] wrBank,
    output logic [BANK_W-1:0] rdBank,
    output logic              rdValid,
    output logic              frameRdy,
    output logic              drop,
    output logic [CNT_W-1:0]  frameCnt,
    output logic [CNT_W-1:0]  dropCnt
);

    bankState_e        state, stateNext_c;
    decision_e         dec_c;
    logic [BANK_W-1:0] nextBank_c;
    logic              lenErrNext_c;

    // Frame-end decision and next state.
    always_comb begin
        stateNext_c  = state;
        dec_c        = NONE;
        lenErrNext_c = 1'b0;
        nextBank_c   = (wrBank == BANK_W'(NUM_BANKS - 1)) ? '0 : wrBank + BANK_W'(1);

        if (frameEnd && pixNz && state != EMPTY) begin
`ifdef FRAME_LEN_CHECK_EN
            if (lenBad) begin
                dec_c        = DROP;
                lenErrNext_c = 1'b1;
            end else
`endif
            if (rdValid && rdLock && nextBank_c == rdBank) begin
                dec_c = DROP;
            end else begin
                dec_c = PUBLISH;
            end
        end

        case (state)
            EMPTY:   if (pixValid) stateNext_c = FILL;
            FILL:    if (dec_c == PUBLISH) stateNext_c = RUN;
            RUN:     stateNext_c = RUN;
            default: stateNext_c = EMPTY;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= EMPTY;
            wrBank   <= '0;
            rdBank   <= '0;
            rdValid  <= 1'b0;
            frameRdy <= 1'b0;
            drop     <= 1'b0;
            frameCnt <= '0;
            dropCnt  <= '0;
`ifdef FRAME_LEN_CHECK_EN
            lenErr   <= 1'b0;
`endif
        end else begin
            state    <= stateNext_c;
            frameRdy <= (dec_c == PUBLISH);
            drop     <= (dec_c == DROP);
`ifdef FRAME_LEN_CHECK_EN
            lenErr   <= lenErrNext_c;
`endif
            if (dec_c == PUBLISH) begin
                rdBank   <= wrBank;
                wrBank   <= nextBank_c;
                rdValid  <= 1'b1;
                frameCnt <= frameCnt + CNT_W'(1);
            end
            if (dec_c == DROP) begin
                dropCnt <= dropCnt + CNT_W'(1);
            end
        end
    end

`ifndef FRAME_LEN_CHECK_EN
    logic unusedLenErr_c;
    assign unusedLenErr_c = lenErrNext_c;
`endif

endmodule

// File: rtl/frame_bank_switch.sv
// N-bank frame-buffer switch: steers pixels into the write bank, publishes completed banks.
// FRAME_LEN_CHECK_EN drops frames whose length differs from FRAME_PIXELS and pulses oLEN_ERR.
module frame_bank_switch
    import frame_bank_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned NUM_BANKS    = NUM_BANKS_DEF,
    parameter int unsigned BANK_W       = BANK_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    frame_bank_switch_if.slave bus
);

    localparam int unsigned PIX_W = $clog2(FRAME_PIXELS + 1) + 1;

    if (BANK_W < bankWidth(NUM_BANKS)) begin : gBadBankW
        $error("BANK_W too narrow for NUM_BANKS");
    end

    logic [PIX_W-1:0]            pixCnt, pixCntNext_c;
    logic [NUM_BANKS*DATA_W-1:0] bankData;
    logic [NUM_BANKS-1:0]        bankWe;
    logic [BANK_W-1:0]           wrBank;
    logic                        pixNz_c;

    // Count includes a pixel arriving together with iFRAME_END.
    always_comb begin
        pixCntNext_c = pixCnt;
        if (bus.iPIX_VALID && pixCnt != '1) pixCntNext_c = pixCnt + PIX_W'(1);
    end
    assign pixNz_c = (pixCntNext_c != '0);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pixCnt   <= '0;
            bankData <= '0;
            bankWe   <= '0;
        end else begin
            pixCnt <= bus.iFRAME_END ? '0 : pixCntNext_c;
            bankWe <= '0;
            if (bus.iPIX_VALID) begin
                bankWe <= NUM_BANKS'(1) << wrBank;
                bankData[wrBank*DATA_W +: DATA_W] <= bus.iGray;
            end
        end
    end

`ifdef FRAME_LEN_CHECK_EN
    logic lenBad_c;
    assign lenBad_c = (pixCntNext_c != PIX_W'(FRAME_PIXELS));
`endif

    frame_bank_ptr #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W),
        .CNT_W     (CNT_W)
    ) uPtr (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .frameEnd (bus.iFRAME_END),
        .pixValid (bus.iPIX_VALID),
        .pixNz    (pixNz_c),
        .rdLock   (bus.iRD_LOCK),
`ifdef FRAME_LEN_CHECK_EN
        .lenBad   (lenBad_c),
        .lenErr   (bus.oLEN_ERR),
`endif
        .wrBank   (wrBank),
        .rdBank   (bus.oRD_BANK),
        .rdValid  (bus.oRD_VALID),
        .frameRdy (bus.oFRAME_RDY),
        .drop     (bus.oDROP),
        .frameCnt (bus.oFRAME_CNT),
        .dropCnt  (bus.oDROP_CNT)
    );

    assign bus.oBANK_DATA = bankData;
    assign bus.oBANK_WE   = bankWe;
    assign bus.oWR_BANK   = wrBank;

endmodule
